// File: rtl/action_executor_if.sv
// Execute handshake between top_system and action_executor.
// The master side (top_system) drives the request level and action code; the
// slave side (the executor) returns status, the running action and the animation
// frame.
interface action_executor_if;
  logic       exec;
  logic [1:0] selected;
  logic       exec_status;
  logic [1:0] action;
  logic [2:0] frame;
  logic       done;
  logic       overrun;

  modport master (
    output exec,
    output selected,
    input  exec_status,
    input  action,
    input  frame,
    input  done,
    input  overrun
  );

  modport slave (
    input  exec,
    input  selected,
    output exec_status,
    output action,
    output frame,
    output done,
    output overrun
  );
endinterface

// File: rtl/action_executor.sv
// action_executor: runs a fixed-length animation (feed / play / clean up) for
// each accepted rising edge of exec.
//
// Behaviour:
// - exec_status is low while the animation runs.
// - exec_status returns high on completion, together with a one-cycle done pulse.
// - A start edge that arrives while busy sets the sticky overrun flag.
//
// Optional feature, selected by the macro ACTION_EXEC_ABORT_EN:
// - exec sampled low while busy aborts the action. There is no done pulse.
// - With the macro undefined, every accepted action runs to completion.
module action_executor #(
  parameter int unsigned TICKS_PER_FRAME = 5,
  parameter int unsigned FRAMES          = 4
) (
  input  logic              clk,
  input  logic              rst,
  action_executor_if.slave  bus
);

  localparam int unsigned TICK_W  = 16;
  localparam int unsigned FRAME_W = 3;
  localparam int unsigned CODE_W  = 2;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_PER_FRAME - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);
  localparam logic [CODE_W-1:0]  CODE_NONE  = CODE_W'(0);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Current state registers
  logic [0:0]         state;
  logic               exec_q;
  logic [TICK_W-1:0]  tick;
  logic [FRAME_W-1:0] frame_r;
  logic [CODE_W-1:0]  action_r;
  logic               status_r;
  logic               done_r;
  logic               overrun_r;

  // Next-state values
  logic [0:0]         state_n;
  logic               exec_q_n;
  logic [TICK_W-1:0]  tick_n;
  logic [FRAME_W-1:0] frame_n;
  logic [CODE_W-1:0]  action_n;
  logic               status_n;
  logic               done_n;
  logic               overrun_n;

  logic               start_c;

  // Rising edge of the request level. exec_q resets high, so a level that is
  // already high when reset releases does not count as an edge.
  assign start_c = bus.exec & ~exec_q;

  // Next-state and output logic
  always_comb begin
    state_n   = state;
    exec_q_n  = bus.exec;
    tick_n    = tick;
    frame_n   = frame_r;
    action_n  = action_r;
    status_n  = status_r;
    done_n    = 1'b0;
    overrun_n = overrun_r;

    case (state)
      ST_IDLE: begin
        // A start edge with the null code is dropped without touching outputs.
        if (start_c && (bus.selected != CODE_NONE)) begin
          state_n  = ST_RUN;
          action_n = bus.selected;
          frame_n  = FRAME_W'(0);
          tick_n   = TICK_W'(0);
          status_n = 1'b0;
        end
      end

      ST_RUN: begin
        // An edge while busy is only flagged. This includes the completion cycle,
        // so the edge is never queued for a later start.
        if (start_c) begin
          overrun_n = 1'b1;
        end
`ifdef ACTION_EXEC_ABORT_EN
        if (!bus.exec) begin
          state_n  = ST_IDLE;
          action_n = CODE_NONE;
          frame_n  = FRAME_W'(0);
          tick_n   = TICK_W'(0);
          status_n = 1'b1;
        end else
`endif
        if (tick == TICK_LAST) begin
          tick_n = TICK_W'(0);
          if (frame_r == FRAME_LAST) begin
            state_n  = ST_IDLE;
            action_n = CODE_NONE;
            frame_n  = FRAME_W'(0);
            status_n = 1'b1;
            done_n   = 1'b1;
          end else begin
            frame_n = frame_r + FRAME_W'(1);
          end
        end else begin
          tick_n = tick + TICK_W'(1);
        end
      end

      default: begin
        state_n  = ST_IDLE;
        action_n = CODE_NONE;
        frame_n  = FRAME_W'(0);
        tick_n   = TICK_W'(0);
        status_n = 1'b1;
      end
    endcase
  end

  // State and output registers, asynchronously cleared by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      exec_q    <= 1'b1;
      tick      <= TICK_W'(0);
      frame_r   <= FRAME_W'(0);
      action_r  <= CODE_NONE;
      status_r  <= 1'b1;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state     <= state_n;
      exec_q    <= exec_q_n;
      tick      <= tick_n;
      frame_r   <= frame_n;
      action_r  <= action_n;
      status_r  <= status_n;
      done_r    <= done_n;
      overrun_r <= overrun_n;
    end
  end

  assign bus.exec_status = status_r;
  assign bus.action      = action_r;
  assign bus.frame       = frame_r;
  assign bus.done        = done_r;
  assign bus.overrun     = overrun_r;

endmodule
